// File: rtl/pdp_mem_port_arbiter_if.sv
// Bundle of the ifu/exec client request/response signals and the memory_pdp port.
// The arbiter uses the slave view; the clients/memory side uses the master view.
interface pdp_mem_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 12
);
    logic                  ifu_rd_req;
    logic [ADDR_WIDTH-1:0] ifu_rd_addr;
    logic [DATA_WIDTH-1:0] ifu_rd_data;
    logic                  ifu_rd_valid;

    logic                  exec_rd_req;
    logic [ADDR_WIDTH-1:0] exec_rd_addr;
    logic                  exec_wr_req;
    logic [ADDR_WIDTH-1:0] exec_wr_addr;
    logic [DATA_WIDTH-1:0] exec_wr_data;
    logic [DATA_WIDTH-1:0] exec_rd_data;
    logic                  exec_rd_valid;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    logic                  busy;
    logic                  proto_err;

    modport slave (
        input  ifu_rd_req, ifu_rd_addr,
        output ifu_rd_data, ifu_rd_valid,
        input  exec_rd_req, exec_rd_addr, exec_wr_req, exec_wr_addr, exec_wr_data,
        output exec_rd_data, exec_rd_valid,
        output mem_req, mem_we, mem_addr, mem_wr_data,
        input  mem_rd_data,
        output busy, proto_err
    );

    modport master (
        output ifu_rd_req, ifu_rd_addr,
        input  ifu_rd_data, ifu_rd_valid,
        output exec_rd_req, exec_rd_addr, exec_wr_req, exec_wr_addr, exec_wr_data,
        input  exec_rd_data, exec_rd_valid,
        input  mem_req, mem_we, mem_addr, mem_wr_data,
        output mem_rd_data,
        input  busy, proto_err
    );
endinterface

// File: rtl/pdp_mem_port_arbiter.sv
// Shares the single memory_pdp port between instruction fetch and the execution unit:
// latches request pulses, arbitrates one access per cycle and steers read data back.
module pdp_mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    pdp_mem_port_arbiter_if.slave bus
);
    localparam int unsigned LAT_W = 3;
    localparam int unsigned CNT_W = 4;
    localparam logic [LAT_W-1:0] LAT_LAST   = LAT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RD_WAIT} state_t;
    typedef enum logic [1:0] {G_NONE, G_IFU_RD, G_EXEC_RD, G_EXEC_WR} grant_t;

    state_t                r_state;
    state_t                w_state_nxt;
    grant_t                w_pick;
    grant_t                w_grant;
    logic [LAT_W-1:0]      r_lat_cnt;
    logic [CNT_W-1:0]      r_starve_cnt;
    logic                  r_rd_owner_ifu;

    logic                  r_ifu_pend;
    logic [ADDR_WIDTH-1:0] r_ifu_addr;
    logic                  r_erd_pend;
    logic [ADDR_WIDTH-1:0] r_erd_addr;
    logic                  r_ewr_pend;
    logic [ADDR_WIDTH-1:0] r_ewr_addr;
    logic [DATA_WIDTH-1:0] r_ewr_data;

    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wr_data;
    logic [DATA_WIDTH-1:0] r_ifu_rd_data;
    logic                  r_ifu_rd_valid;
    logic [DATA_WIDTH-1:0] r_exec_rd_data;
    logic                  r_exec_rd_valid;
    logic                  r_busy;
    logic                  r_proto_err;

    // A pulse in the current cycle counts as pending so it can be granted at this edge.
    logic                  w_ifu_avail;
    logic                  w_erd_avail;
    logic                  w_ewr_avail;
    logic                  w_any_avail;
    logic                  w_rd_done;
    logic [ADDR_WIDTH-1:0] w_ifu_addr;
    logic [ADDR_WIDTH-1:0] w_erd_addr;
    logic [ADDR_WIDTH-1:0] w_ewr_addr;
    logic [DATA_WIDTH-1:0] w_ewr_data;

    assign w_ifu_avail = r_ifu_pend | bus.ifu_rd_req;
    assign w_erd_avail = r_erd_pend | bus.exec_rd_req;
    assign w_ewr_avail = r_ewr_pend | bus.exec_wr_req;
    assign w_any_avail = w_ifu_avail | w_erd_avail | w_ewr_avail;
    assign w_rd_done   = (r_state == S_RD_WAIT) && (r_lat_cnt == LAT_LAST);

    assign w_ifu_addr  = r_ifu_pend ? r_ifu_addr : bus.ifu_rd_addr;
    assign w_erd_addr  = r_erd_pend ? r_erd_addr : bus.exec_rd_addr;
    assign w_ewr_addr  = r_ewr_pend ? r_ewr_addr : bus.exec_wr_addr;
    assign w_ewr_data  = r_ewr_pend ? r_ewr_data : bus.exec_wr_data;

    // Priority select with starvation override for the fetch slot.
    always_comb begin
        w_pick = G_NONE;
        if (w_ifu_avail && (r_starve_cnt == STARVE_LIM)) begin
            w_pick = G_IFU_RD;
        end else if (w_ewr_avail) begin
            w_pick = G_EXEC_WR;
        end else if (w_erd_avail) begin
            w_pick = G_EXEC_RD;
        end else if (w_ifu_avail) begin
            w_pick = G_IFU_RD;
        end
    end

    // Next-state and grant decision; a grant here becomes mem_req in the next cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = G_NONE;
        case (r_state)
            S_IDLE: begin
                if (w_any_avail) begin
                    w_state_nxt = S_ISSUE;
                    w_grant     = w_pick;
                end
            end
            S_ISSUE: begin
                if (!r_mem_we) begin
                    w_state_nxt = S_RD_WAIT;
                end else if (w_any_avail) begin
                    w_state_nxt = S_ISSUE;
                    w_grant     = w_pick;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RD_WAIT: begin
                if (w_rd_done) begin
                    if (w_any_avail) begin
                        w_state_nxt = S_ISSUE;
                        w_grant     = w_pick;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pending slots: a pulse into a full slot is dropped and flagged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ifu_pend  <= 1'b0;
            r_ifu_addr  <= '0;
            r_erd_pend  <= 1'b0;
            r_erd_addr  <= '0;
            r_ewr_pend  <= 1'b0;
            r_ewr_addr  <= '0;
            r_ewr_data  <= '0;
            r_proto_err <= 1'b0;
        end else begin
            if (r_ifu_pend) begin
                if (w_grant == G_IFU_RD) r_ifu_pend <= 1'b0;
            end else if (bus.ifu_rd_req && (w_grant != G_IFU_RD)) begin
                r_ifu_pend <= 1'b1;
                r_ifu_addr <= bus.ifu_rd_addr;
            end

            if (r_erd_pend) begin
                if (w_grant == G_EXEC_RD) r_erd_pend <= 1'b0;
            end else if (bus.exec_rd_req && (w_grant != G_EXEC_RD)) begin
                r_erd_pend <= 1'b1;
                r_erd_addr <= bus.exec_rd_addr;
            end

            if (r_ewr_pend) begin
                if (w_grant == G_EXEC_WR) r_ewr_pend <= 1'b0;
            end else if (bus.exec_wr_req && (w_grant != G_EXEC_WR)) begin
                r_ewr_pend <= 1'b1;
                r_ewr_addr <= bus.exec_wr_addr;
                r_ewr_data <= bus.exec_wr_data;
            end

            if ((r_ifu_pend && bus.ifu_rd_req) || (r_erd_pend && bus.exec_rd_req) ||
                (r_ewr_pend && bus.exec_wr_req)) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    // Starvation counter and read-wait bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starve_cnt   <= '0;
            r_lat_cnt      <= '0;
            r_rd_owner_ifu <= 1'b0;
        end else begin
            if ((w_grant == G_IFU_RD) || !w_ifu_avail) begin
                r_starve_cnt <= '0;
            end else if (((w_grant == G_EXEC_RD) || (w_grant == G_EXEC_WR)) &&
                         (r_starve_cnt != STARVE_LIM)) begin
                r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            end

            if (w_grant == G_IFU_RD) begin
                r_rd_owner_ifu <= 1'b1;
            end else if (w_grant == G_EXEC_RD) begin
                r_rd_owner_ifu <= 1'b0;
            end

            if ((r_state == S_ISSUE) && (w_state_nxt == S_RD_WAIT)) begin
                r_lat_cnt <= '0;
            end else if ((r_state == S_RD_WAIT) && !w_rd_done) begin
                r_lat_cnt <= r_lat_cnt + LAT_W'(1);
            end
        end
    end

    // Registered memory strobe, address and write data; address/data are zero when idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wr_data <= '0;
            r_busy        <= 1'b0;
        end else begin
            r_mem_req     <= (w_grant != G_NONE);
            r_mem_we      <= (w_grant == G_EXEC_WR);
            r_busy        <= (w_state_nxt != S_IDLE);
            r_mem_wr_data <= '0;
            case (w_grant)
                G_IFU_RD:  r_mem_addr <= w_ifu_addr;
                G_EXEC_RD: r_mem_addr <= w_erd_addr;
                G_EXEC_WR: begin
                    r_mem_addr    <= w_ewr_addr;
                    r_mem_wr_data <= w_ewr_data;
                end
                default:   r_mem_addr <= '0;
            endcase
        end
    end

    // Read data steering to the owner of the outstanding read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ifu_rd_data   <= '0;
            r_ifu_rd_valid  <= 1'b0;
            r_exec_rd_data  <= '0;
            r_exec_rd_valid <= 1'b0;
        end else begin
            r_ifu_rd_valid  <= w_rd_done && r_rd_owner_ifu;
            r_exec_rd_valid <= w_rd_done && !r_rd_owner_ifu;
            if (w_rd_done && r_rd_owner_ifu) r_ifu_rd_data <= bus.mem_rd_data;
            if (w_rd_done && !r_rd_owner_ifu) r_exec_rd_data <= bus.mem_rd_data;
        end
    end

    assign bus.mem_req       = r_mem_req;
    assign bus.mem_we        = r_mem_we;
    assign bus.mem_addr      = r_mem_addr;
    assign bus.mem_wr_data   = r_mem_wr_data;
    assign bus.ifu_rd_data   = r_ifu_rd_data;
    assign bus.ifu_rd_valid  = r_ifu_rd_valid;
    assign bus.exec_rd_data  = r_exec_rd_data;
    assign bus.exec_rd_valid = r_exec_rd_valid;
    assign bus.busy          = r_busy;
    assign bus.proto_err     = r_proto_err;
endmodule

// File: tb/tb_pdp_mem_port_arbiter.sv
// Directed bench for pdp_mem_port_arbiter with a one-cycle-latency memory model.
module tb_pdp_mem_port_arbiter;
    localparam int unsigned AW = 12;
    localparam int unsigned DW = 12;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    pdp_mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    pdp_mem_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(1), .STARVE_MAX(4)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;

    // Memory: writes land at the strobe edge, read data appears one cycle after the strobe.
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (bus.mem_req && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wr_data;
        if (bus.mem_req && !bus.mem_we) bus.mem_rd_data <= mem[bus.mem_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        bus.ifu_rd_req  = 1'b0;
        bus.exec_rd_req = 1'b0;
        bus.exec_wr_req = 1'b0;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        step();
        pl_en = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (!bus.busy) break;
            step();
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL drain_timeout: busy=%0b want 0", bus.busy);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        clear_reqs();
        bus.ifu_rd_addr = '0; bus.exec_rd_addr = '0;
        bus.exec_wr_addr = '0; bus.exec_wr_data = '0;
        preload(12'o0200, 12'o1234);
        preload(12'o0010, 12'o0111);
        preload(12'o0020, 12'o0222);
        preload(12'o0030, 12'o0333);
        preload(12'o0040, 12'o0444);
        preload(12'o0060, 12'o0660);
        preload(12'o0061, 12'o0661);
        preload(12'o0062, 12'o0662);
        preload(12'o0070, 12'o0770);
        preload(12'o0071, 12'o0771);
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.ifu_rd_valid, bus.exec_rd_valid, bus.busy, bus.proto_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {bus.mem_req, bus.mem_we, bus.ifu_rd_valid, bus.exec_rd_valid, bus.busy, bus.proto_err});
        end
        checks++;
        if ({bus.mem_addr, bus.mem_wr_data, bus.ifu_rd_data, bus.exec_rd_data} !== 48'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0",
                     {bus.mem_addr, bus.mem_wr_data, bus.ifu_rd_data, bus.exec_rd_data});
        end
        @(negedge clk);
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_exec_read();
        bus.exec_rd_req = 1'b1; bus.exec_rd_addr = 12'o0200;
        step(); clear_reqs();
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 12'o0200}) begin
            errors++;
            $display("FAIL rd_issue: req/we/addr=%b/%b/%o want 1/0/200", bus.mem_req, bus.mem_we, bus.mem_addr);
        end
        step();
        checks++;
        if ({bus.mem_req, bus.mem_addr, bus.exec_rd_valid} !== 14'h0) begin
            errors++;
            $display("FAIL rd_wait_quiet: req=%b addr=%o valid=%b want 0/0/0", bus.mem_req, bus.mem_addr, bus.exec_rd_valid);
        end
        step();
        checks++;
        if ({bus.exec_rd_valid, bus.exec_rd_data, bus.ifu_rd_valid} !== {1'b1, 12'o1234, 1'b0}) begin
            errors++;
            $display("FAIL rd_return: valid=%b data=%o ifu_valid=%b want 1/1234/0",
                     bus.exec_rd_valid, bus.exec_rd_data, bus.ifu_rd_valid);
        end
        step();
        checks++;
        if ({bus.exec_rd_valid, bus.exec_rd_data, bus.busy} !== {1'b0, 12'o1234, 1'b0}) begin
            errors++;
            $display("FAIL rd_hold: valid=%b data=%o busy=%b want 0/1234/0",
                     bus.exec_rd_valid, bus.exec_rd_data, bus.busy);
        end
    endtask

    task automatic test_write_then_read();
        bus.exec_wr_req = 1'b1; bus.exec_wr_addr = 12'o0050; bus.exec_wr_data = 12'o7777;
        bus.exec_rd_req = 1'b1; bus.exec_rd_addr = 12'o0050;
        step(); clear_reqs();
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wr_data} !== {1'b1, 1'b1, 12'o0050, 12'o7777}) begin
            errors++;
            $display("FAIL wr_first: req/we/addr/data=%b/%b/%o/%o want 1/1/50/7777",
                     bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wr_data);
        end
        step();
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wr_data} !== {1'b1, 1'b0, 12'o0050, 12'o0000}) begin
            errors++;
            $display("FAIL rd_second: req/we/addr/data=%b/%b/%o/%o want 1/0/50/0",
                     bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wr_data);
        end
        step();
        step();
        checks++;
        if ({bus.exec_rd_valid, bus.exec_rd_data} !== {1'b1, 12'o7777}) begin
            errors++;
            $display("FAIL raw_data: valid=%b data=%o want 1/7777", bus.exec_rd_valid, bus.exec_rd_data);
        end
        wait_idle();
    endtask

    task automatic test_ifu_exec_same_cycle();
        bus.ifu_rd_req = 1'b1;  bus.ifu_rd_addr = 12'o0010;
        bus.exec_rd_req = 1'b1; bus.exec_rd_addr = 12'o0020;
        step(); clear_reqs();
        checks++;
        if ({bus.mem_req, bus.mem_addr} !== {1'b1, 12'o0020}) begin
            errors++;
            $display("FAIL both_exec_first: req=%b addr=%o want 1/20", bus.mem_req, bus.mem_addr);
        end
        step();
        step();
        checks++;
        if ({bus.exec_rd_valid, bus.exec_rd_data, bus.ifu_rd_valid, bus.mem_req, bus.mem_addr}
            !== {1'b1, 12'o0222, 1'b0, 1'b1, 12'o0010}) begin
            errors++;
            $display("FAIL both_exec_ret: ev=%b ed=%o iv=%b req=%b addr=%o want 1/222/0/1/10",
                     bus.exec_rd_valid, bus.exec_rd_data, bus.ifu_rd_valid, bus.mem_req, bus.mem_addr);
        end
        step();
        checks++;
        if ({bus.exec_rd_valid, bus.ifu_rd_valid} !== 2'b00) begin
            errors++;
            $display("FAIL both_gap: ev=%b iv=%b want 0/0", bus.exec_rd_valid, bus.ifu_rd_valid);
        end
        step();
        checks++;
        if ({bus.ifu_rd_valid, bus.ifu_rd_data, bus.exec_rd_valid} !== {1'b1, 12'o0111, 1'b0}) begin
            errors++;
            $display("FAIL both_ifu_ret: iv=%b id=%o ev=%b want 1/111/0",
                     bus.ifu_rd_valid, bus.ifu_rd_data, bus.exec_rd_valid);
        end
        wait_idle();
    endtask

    task automatic starve_round(input int round);
        int  exec_grants;
        bit  got_ifu;
        exec_grants = 0;
        got_ifu     = 1'b0;
        bus.ifu_rd_req = 1'b1;  bus.ifu_rd_addr = 12'o0030;
        bus.exec_rd_req = 1'b1; bus.exec_rd_addr = 12'o0040;
        for (int c = 0; c < 60 && !got_ifu; c++) begin
            step(); clear_reqs();
            if (bus.mem_req) begin
                if (bus.mem_addr == 12'o0030) begin
                    got_ifu = 1'b1;
                end else begin
                    exec_grants++;
                    bus.exec_rd_req = 1'b1;
                end
            end
        end
        clear_reqs();
        checks++;
        if (!got_ifu || exec_grants != 4) begin
            errors++;
            $display("FAIL starve_round%0d: ifu_granted=%0b exec_grants=%0d want 1/4", round, got_ifu, exec_grants);
        end
        wait_idle();
    endtask

    task automatic test_starvation();
        starve_round(1);
        starve_round(2);
        checks++;
        if (bus.proto_err !== 1'b0) begin
            errors++;
            $display("FAIL proto_clean: proto_err=%b want 0", bus.proto_err);
        end
    endtask

    task automatic test_proto_err();
        int ifu_valids;
        int ifu_issues;
        logic [AW-1:0] ifu_issue_addr;
        logic [DW-1:0] ifu_data;
        ifu_valids = 0; ifu_issues = 0; ifu_issue_addr = '0; ifu_data = '0;
        bus.exec_rd_req = 1'b1; bus.exec_rd_addr = 12'o0060;
        bus.ifu_rd_req = 1'b1;  bus.ifu_rd_addr = 12'o0061;
        step(); clear_reqs();
        bus.ifu_rd_req = 1'b1;  bus.ifu_rd_addr = 12'o0062;
        step(); clear_reqs();
        checks++;
        if (bus.proto_err !== 1'b1) begin
            errors++;
            $display("FAIL proto_set: proto_err=%b want 1", bus.proto_err);
        end
        for (int c = 0; c < 10; c++) begin
            if (bus.mem_req && bus.mem_addr != 12'o0060) begin
                ifu_issues++;
                ifu_issue_addr = bus.mem_addr;
            end
            if (bus.ifu_rd_valid) begin
                ifu_valids++;
                ifu_data = bus.ifu_rd_data;
            end
            step();
        end
        checks++;
        if (ifu_issues != 1 || ifu_issue_addr !== 12'o0061) begin
            errors++;
            $display("FAIL proto_first_addr: issues=%0d addr=%o want 1/61", ifu_issues, ifu_issue_addr);
        end
        checks++;
        if (ifu_valids != 1 || ifu_data !== 12'o0661) begin
            errors++;
            $display("FAIL proto_one_valid: valids=%0d data=%o want 1/661", ifu_valids, ifu_data);
        end
        checks++;
        if (bus.proto_err !== 1'b1) begin
            errors++;
            $display("FAIL proto_sticky: proto_err=%b want 1", bus.proto_err);
        end
    endtask

    task automatic test_reset_in_rd_wait();
        int valids;
        valids = 0;
        bus.exec_rd_req = 1'b1; bus.exec_rd_addr = 12'o0070;
        step(); clear_reqs();
        step();
        checks++;
        if ({bus.busy, bus.exec_rd_valid} !== 2'b10) begin
            errors++;
            $display("FAIL rst_pre: busy=%b valid=%b want 1/0", bus.busy, bus.exec_rd_valid);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.busy, bus.proto_err, bus.exec_rd_valid, bus.ifu_rd_valid,
             bus.mem_addr, bus.ifu_rd_data, bus.exec_rd_data} !== 42'h0) begin
            errors++;
            $display("FAIL rst_async: req=%b busy=%b perr=%b addr=%o id=%o ed=%o want all 0",
                     bus.mem_req, bus.busy, bus.proto_err, bus.mem_addr, bus.ifu_rd_data, bus.exec_rd_data);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            if (bus.exec_rd_valid || bus.ifu_rd_valid) valids++;
        end
        checks++;
        if (valids != 0) begin
            errors++;
            $display("FAIL rst_no_valid: valid pulses=%0d want 0", valids);
        end
        bus.exec_rd_req = 1'b1; bus.exec_rd_addr = 12'o0071;
        step(); clear_reqs();
        checks++;
        if ({bus.mem_req, bus.mem_addr} !== {1'b1, 12'o0071}) begin
            errors++;
            $display("FAIL rst_next_issue: req=%b addr=%o want 1/71", bus.mem_req, bus.mem_addr);
        end
        step();
        step();
        checks++;
        if ({bus.exec_rd_valid, bus.exec_rd_data} !== {1'b1, 12'o0771}) begin
            errors++;
            $display("FAIL rst_next_data: valid=%b data=%o want 1/771", bus.exec_rd_valid, bus.exec_rd_data);
        end
    endtask

    initial begin
        test_reset();
        test_exec_read();
        test_write_then_read();
        test_ifu_exec_same_cycle();
        test_starvation();
        test_proto_err();
        test_reset_in_rd_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
